// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction memory slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_mem_pkg;

  // Width of the reference NOP encoding; users resize it to their DATA_W.
  localparam int NOP_W = 32;
  localparam logic [NOP_W-1:0] NOP = '0;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int PAR_MAX_W = 256;

  function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// Latency: write lands on the rising edge; read is combinational.
// Backpressure: none; the controller decides when to write.
// Ports: we/waddr/wdata write port, raddr/rdata read port.
// Optional (INSTR_MEM_PARITY_EN): wpar_flip inverts the stored parity bit,
// rpar returns the stored parity bit of the addressed word.
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
`ifdef INSTR_MEM_PARITY_EN
  ,
  input  logic              wpar_flip,
  output logic              rpar
`endif
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Callers must not use rdata when raddr >= DEPTH.
  assign rdata = mem[raddr];

`ifdef INSTR_MEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) par_mem[waddr] <= calc_parity(PAR_MAX_W'(wdata)) ^ wpar_flip;
  end

  assign rpar = par_mem[raddr];
`endif

endmodule

// File: rtl/instr_mem_ctrl.sv
// Writable instruction memory with post-reset NOP clear and a registered fetch port.
// Latency: 1 cycle from fetch accept to rd_valid; init clear takes DEPTH cycles.
// Backpressure: rd_req_ready drops while rd_valid is held by !rd_ready or during init.
// Ports: clk/rst_n (async active-low); init_busy; prog_we/prog_addr/prog_data/prog_err
// program port; rd_req/rd_addr/rd_req_ready request side; rd_valid/rd_ready/rd_data/
// rd_addr_err response side. Macro INSTR_MEM_PARITY_EN adds prog_par_flip and rd_par_err.
module instr_mem_ctrl
  import instr_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_busy,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_err,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_req_ready,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_addr_err
`ifdef INSTR_MEM_PARITY_EN
  ,
  input  logic              prog_par_flip,
  output logic              rd_par_err
`endif
);

  // One extra bit so DEPTH == 2^ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_W  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   LAST_IDX = DEPTH_W - 1'b1;
  localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_IDX) state_nxt = READY;
      end
      READY:   ;
      default: state_nxt = INIT;
    endcase
  end

  logic is_init, prog_ok, prog_drop, rd_in_range, accept, bypass;

  assign is_init      = (state == INIT);
  assign init_busy    = is_init;
  assign prog_ok      = prog_we && !is_init && ({1'b0, prog_addr} < DEPTH_W);
  assign prog_drop    = prog_we && !prog_ok;
  assign rd_in_range  = ({1'b0, rd_addr} < DEPTH_W);
  assign rd_req_ready = !is_init && (!rd_valid || rd_ready);
  assign accept       = rd_req && rd_req_ready;
  // Write-first: a fetch on the same edge as a write to its address sees the new data.
  assign bypass       = prog_ok && (prog_addr == rd_addr);

  // The init sequencer owns the write port while clearing.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata, fetch_word;

  assign mem_we     = is_init || prog_ok;
  assign mem_waddr  = is_init ? cnt[ADDR_W-1:0] : prog_addr;
  assign mem_wdata  = is_init ? NOP_WORD : prog_data;
  assign fetch_word = bypass ? prog_data : mem_rdata;

`ifdef INSTR_MEM_PARITY_EN
  logic mem_wflip, mem_rpar, fetch_par, fetch_par_err;

  assign mem_wflip     = !is_init && prog_par_flip;
  assign fetch_par     = bypass ? (calc_parity(PAR_MAX_W'(prog_data)) ^ prog_par_flip) : mem_rpar;
  assign fetch_par_err = fetch_par ^ calc_parity(PAR_MAX_W'(fetch_word));
`endif

  instr_mem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk      (clk),
    .we       (mem_we),
    .waddr    (mem_waddr),
    .wdata    (mem_wdata),
    .raddr    (rd_addr),
    .rdata    (mem_rdata)
`ifdef INSTR_MEM_PARITY_EN
    ,
    .wpar_flip(mem_wflip),
    .rpar     (mem_rpar)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      rd_addr_err <= 1'b0;
      prog_err    <= 1'b0;
    end else begin
      prog_err <= prog_drop;
      if (accept) begin
        rd_valid    <= 1'b1;
        rd_data     <= rd_in_range ? fetch_word : NOP_WORD;
        rd_addr_err <= !rd_in_range;
      end else if (rd_valid && rd_ready) begin
        // Drain: data stays put, only the valid flag drops.
        rd_valid <= 1'b0;
      end
    end
  end

`ifdef INSTR_MEM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_par_err <= 1'b0;
    end else if (accept) begin
      rd_par_err <= rd_in_range ? fetch_par_err : 1'b0;
    end
  end
`endif

endmodule
